hex_display_bank: RTL and testbench



---
 rtl/hex_display_pkg.sv | 46 ++++
 rtl/hex_seg_encoder.sv | 21 ++
 rtl/hex_display_bank.sv | 168 ++++++++++++++++
 tb/tb_hex_display_bank.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Shared types, segment constants and helpers for the multi-digit HEX display driver.
package hex_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    typedef enum logic {
        IDLE,
        CONVERT
    } state_t;

    // Active-low glyphs, bit 0 = top segment through bit 6 = middle segment.
    function automatic logic [6:0] glyph(input logic [3:0] d);
        logic [6:0] seg;
        case (d)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // Largest value representable with n decimal digits; the caller truncates to its data width.
    function automatic logic [31:0] dec_limit(input int n);
        logic [31:0] v;
        v = 32'd1;
        for (int i = 0; i < n; i++) begin
            v = v * 32'd10;
        end
        return v - 32'd1;
    endfunction

endpackage

// File: rtl/hex_seg_encoder.sv
// One digit of the display: nibble plus blank/dash overrides to active-low segments.
module hex_seg_encoder
    import hex_display_pkg::*;
(
    input  logic [3:0] digit,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);

    always_comb begin
        if (blank) begin
            seg = SEG_BLANK;
        end else if (dash) begin
            seg = SEG_DASH;
        end else begin
            seg = glyph(digit);
        end
    end

endmodule

// File: rtl/hex_display_bank.sv
// Multi-digit seven-segment driver: hex or decimal (double-dabble) display with
// leading-zero blanking, per-digit blink and decimal overflow indication.
module hex_display_bank
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS = 6,
    parameter int BLINK_HALF = 25_000_000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic                    load_mode,
    input  logic                    blank_lz,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic                    busy,
    output logic                    overflow,
    output logic [7*NUM_DIGITS-1:0] hex_out
);

    localparam int DATA_W = 4 * NUM_DIGITS;
    localparam int CW     = $clog2(DATA_W + 1);
    localparam int BW     = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [DATA_W-1:0] DEC_LIMIT  = DATA_W'(dec_limit(NUM_DIGITS));
    localparam logic [CW-1:0]     LAST_ITER  = CW'(DATA_W);
    localparam logic [BW-1:0]     BLINK_LAST = BW'(BLINK_HALF - 1);

    state_t            state;
    logic [CW-1:0]     iter_cnt;
    logic              disp_valid;
    logic              disp_dash;
    logic              disp_lz;
    logic              lz_pending;
    logic [DATA_W-1:0] disp_digits;
    logic [DATA_W-1:0] bcd;
    logic [DATA_W-1:0] bcd_adj;
    logic [DATA_W-1:0] bin;
    logic [BW-1:0]     blink_cnt;
    logic              blink_phase;
    logic              accept;
    logic              over_limit;
    logic              all_zero;
    logic [NUM_DIGITS-1:0] lz_blank;
    logic [NUM_DIGITS-1:0] digit_blank;

    assign accept     = load_valid & load_ready;
    assign over_limit = load_data > DEC_LIMIT;

    // Control: handshake, FSM and display status flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            load_ready <= 1'b1;
            busy       <= 1'b0;
            overflow   <= 1'b0;
            disp_valid <= 1'b0;
            disp_dash  <= 1'b0;
            iter_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (!load_mode) begin
                            disp_valid <= 1'b1;
                            disp_dash  <= 1'b0;
                            overflow   <= 1'b0;
                        end else if (over_limit) begin
                            disp_valid <= 1'b1;
                            disp_dash  <= 1'b1;
                            overflow   <= 1'b1;
                        end else begin
                            state      <= CONVERT;
                            busy       <= 1'b1;
                            load_ready <= 1'b0;
                            iter_cnt   <= '0;
                        end
                    end
                end
                CONVERT: begin
                    if (iter_cnt == LAST_ITER) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        load_ready <= 1'b1;
                        disp_valid <= 1'b1;
                        disp_dash  <= 1'b0;
                        overflow   <= 1'b0;
                    end else begin
                        iter_cnt <= iter_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bcd_adj = bcd;
        for (int j = 0; j < NUM_DIGITS; j++) begin
            if (bcd[4*j +: 4] >= 4'd5) begin
                bcd_adj[4*j +: 4] = bcd[4*j +: 4] + 4'd3;
            end
        end
    end

    // Datapath: no reset needed, the control flags above gate everything visible.
    always_ff @(posedge clock) begin
        if (accept) begin
            lz_pending <= blank_lz;
            if (!load_mode) begin
                disp_digits <= load_data;
                disp_lz     <= blank_lz;
            end else if (!over_limit) begin
                bin <= load_data;
                bcd <= '0;
            end
        end else if (state == CONVERT) begin
            if (iter_cnt == LAST_ITER) begin
                disp_digits <= bcd;
                disp_lz     <= lz_pending;
            end else begin
                {bcd, bin} <= {bcd_adj, bin} << 1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Walk down from the top digit; digit 0 is never blanked as a leading zero.
    always_comb begin
        all_zero = 1'b1;
        lz_blank = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            all_zero    = all_zero & (disp_digits[4*i +: 4] == 4'd0);
            lz_blank[i] = disp_lz & all_zero & (i != 0);
        end
    end

    always_comb begin
        digit_blank = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            digit_blank[i] = ~disp_valid
                           | (blink_phase & blink_mask[i])
                           | (lz_blank[i] & ~disp_dash);
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        hex_seg_encoder u_enc (
            .digit (disp_digits[4*i +: 4]),
            .blank (digit_blank[i]),
            .dash  (disp_dash),
            .seg   (hex_out[7*i +: 7])
        );
    end

endmodule

// File: tb/tb_hex_display_bank.sv
// Directed bench for hex_display_bank (6 digits, short blink period).
module tb_hex_display_bank;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [23:0] load_data = '0;
    logic        load_mode = 1'b0;
    logic        blank_lz = 1'b0;
    logic [5:0]  blink_mask = '0;
    logic        busy;
    logic        overflow;
    logic [41:0] hex_out;

    int compared   = 0;
    int mismatched = 0;

    hex_display_bank #(
        .NUM_DIGITS (6),
        .BLINK_HALF (4)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_mode  (load_mode),
        .blank_lz   (blank_lz),
        .blink_mask (blink_mask),
        .busy       (busy),
        .overflow   (overflow),
        .hex_out    (hex_out)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [23:0] data, input logic mode, input logic lz);
        load_valid = 1'b1;
        load_data  = data;
        load_mode  = mode;
        blank_lz   = lz;
        step();
        load_valid = 1'b0;
    endtask

    function automatic logic [41:0] pack(input logic [6:0] d5, input logic [6:0] d4,
                                         input logic [6:0] d3, input logic [6:0] d2,
                                         input logic [6:0] d1, input logic [6:0] d0);
        return {d5, d4, d3, d2, d1, d0};
    endfunction

    function automatic logic [6:0] dig(input int i);
        return hex_out[7*i +: 7];
    endfunction

    initial begin
        int n;
        logic [6:0] cur;
        logic [41:0] prev_disp;

        step();
        step();
        reset = 1'b0;
        check("reset_hex_out", hex_out, 42'h3FF_FFFF_FFFF);
        check("reset_ready", load_ready, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_overflow", overflow, 1'b0);

        load(24'h00A3F1, 1'b0, 1'b0);
        check("hex_a3f1", hex_out, pack(7'h40, 7'h40, 7'h08, 7'h30, 7'h0E, 7'h79));
        check("hex_ready", load_ready, 1'b1);

        load(24'h00A3F1, 1'b0, 1'b1);
        check("hex_a3f1_lz", hex_out, pack(7'h7F, 7'h7F, 7'h08, 7'h30, 7'h0E, 7'h79));

        prev_disp = pack(7'h7F, 7'h7F, 7'h08, 7'h30, 7'h0E, 7'h79);
        load(24'd123456, 1'b1, 1'b0);
        check("dec_busy", busy, 1'b1);
        check("dec_not_ready", load_ready, 1'b0);
        n = 0;
        while (!load_ready && n < 100) begin
            if (n == 5) begin
                load_valid = 1'b1;
                load_data  = 24'h111111;
                load_mode  = 1'b0;
            end else begin
                load_valid = 1'b0;
            end
            if (n == 10) check("dec_hold_old", hex_out, prev_disp);
            step();
            n++;
        end
        load_valid = 1'b0;
        check("dec_latency", n, 25);
        check("dec_123456", hex_out, pack(7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02));
        check("dec_busy_done", busy, 1'b0);

        load(24'd1_000_000, 1'b1, 1'b1);
        check("ovf_flag", overflow, 1'b1);
        check("ovf_dashes", hex_out, pack(7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F));
        check("ovf_ready", load_ready, 1'b1);

        load(24'h000000, 1'b0, 1'b1);
        check("zero_ovf_clear", overflow, 1'b0);
        check("zero_lz", hex_out, pack(7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40));

        load(24'd999999, 1'b1, 1'b0);
        n = 0;
        while (!load_ready && n < 100) begin
            step();
            n++;
        end
        check("max_latency", n, 25);
        check("max_999999", hex_out, pack(7'h10, 7'h10, 7'h10, 7'h10, 7'h10, 7'h10));
        check("max_no_ovf", overflow, 1'b0);

        blink_mask = 6'b000001;
        load(24'h000008, 1'b0, 1'b0);
        cur = dig(0);
        n = 0;
        while (dig(0) == cur && n < 6) begin
            step();
            n++;
        end
        check("blink_toggles", (n < 6), 1'b1);
        cur = dig(0);
        check("blink_value", (cur == 7'h00 || cur == 7'h7F), 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            check("blink_hold", dig(0), cur);
        end
        step();
        check("blink_flip", dig(0), (cur == 7'h00) ? 7'h7F : 7'h00);
        check("blink_others", hex_out[41:7], {7'h40, 7'h40, 7'h40, 7'h40, 7'h40});
        if (dig(0) != 7'h7F) begin
            repeat (4) step();
        end
        check("blink_off_phase", dig(0), 7'h7F);
        blink_mask = 6'b000000;
        #1;
        check("blink_mask_comb", dig(0), 7'h00);

        load(24'd123456, 1'b1, 1'b0);
        repeat (9) step();
        check("abort_busy_before", busy, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_hex_out", hex_out, 42'h3FF_FFFF_FFFF);
        check("abort_busy", busy, 1'b0);
        check("abort_ready", load_ready, 1'b1);
        load(24'h123456, 1'b0, 1'b0);
        check("post_reset_load", hex_out, pack(7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02));
        repeat (30) step();
        check("post_reset_hold", hex_out, pack(7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
